// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding request to a
// variable-latency instruction memory, 2-entry prefetch FIFO and IF/ID register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [1:0]  dbg_state,
   output logic [1:0]  dbg_fifo_count
);

   // Memory handshake: imem_req is a one-cycle pulse that memory always accepts;
   // imem_rvalid returns exactly one response per request, at least one cycle later.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_fetch;
   logic [31:0] req_pc;
   logic [31:0] fifo_pc    [2];
   logic [31:0] fifo_instr [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  fifo_count;
   logic        push;
   logic        pop;
   logic        issue;
   logic [2:0]  occupancy;

   always_comb begin
      pop       = !stall && !redirect && (fifo_count != 2'd0);
      push      = !redirect && imem_rvalid && (state == S_WAIT);
      // Slots already claimed by buffered or in-flight words after this cycle's pop.
      occupancy = {1'b0, fifo_count} + {2'b00, state == S_WAIT} - {2'b00, pop};
      issue     = !redirect && ((state == S_IDLE) || imem_rvalid) && (occupancy < 3'd2);
      imem_req  = issue && reset;
      imem_addr = pc_fetch;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (issue) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (redirect)         state_nxt = imem_rvalid ? S_IDLE : S_DISCARD;
            else if (imem_rvalid) state_nxt = issue ? S_WAIT : S_IDLE;
         end
         S_DISCARD: begin
            if (redirect)         state_nxt = imem_rvalid ? S_IDLE : S_DISCARD;
            else if (imem_rvalid) state_nxt = issue ? S_WAIT : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_fetch   <= RESET_PC;
         req_pc     <= RESET_PC;
         fifo_count <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         id_valid   <= 1'b0;
         id_instr   <= 32'h00000000;
         id_pc      <= 32'h00000000;
      end else if (redirect) begin
         pc_fetch   <= redirect_pc & ~32'h00000003;
         fifo_count <= 2'd0;
         rd_ptr     <= 1'b0;
         wr_ptr     <= 1'b0;
         id_valid   <= 1'b0;
         id_instr   <= 32'h00000000;
      end else begin
         if (issue) begin
            req_pc   <= pc_fetch;
            pc_fetch <= pc_fetch + 32'd4;
         end
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
         if (!stall) begin
            if (fifo_count != 2'd0) begin
               id_valid <= 1'b1;
               id_instr <= fifo_instr[rd_ptr];
               id_pc    <= fifo_pc[rd_ptr];
            end else begin
               id_valid <= 1'b0;
               id_instr <= 32'h00000000;
            end
         end
      end
   end

   // Storage needs no reset: fifo_count alone says which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc[wr_ptr]    <= req_pc;
         fifo_instr[wr_ptr] <= imem_rdata;
      end
   end

   assign dbg_state      = state;
   assign dbg_fifo_count = fifo_count;

endmodule
